// File: rtl/avr_pp_responder.sv
// rtl/avr_pp_responder.sv - AVR HV parallel programming target emulator; AVR_PP_RESP_EEPROM_EN adds EEPROM
module avr_pp_responder #(
  parameter int         FLASH_AW    = 12,
  parameter int         PAGE_AW     = 5,
  parameter int         BUSY_CYCLES = 16,
  parameter logic [7:0] SIG0        = 8'h1E,
  parameter logic [7:0] SIG1        = 8'h93,
  parameter logic [7:0] SIG2        = 8'h07,
  parameter logic [7:0] FUSE_LO_RST = 8'hE1,
  parameter logic [7:0] FUSE_HI_RST = 8'hD9,
  parameter int         EE_AW       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       xtal,
  input  logic       oe_n,
  input  logic       wr_n,
  input  logic       bs1,
  input  logic       bs2,
  input  logic       xa0,
  input  logic       xa1,
  input  logic       pagel,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       rdy_bsy
);

  localparam logic [7:0] CMD_ERASE = 8'h80;
  localparam logic [7:0] CMD_PGWR  = 8'h10;
  localparam logic [7:0] CMD_FUSE  = 8'h40;
  localparam logic [7:0] CMD_LOCK  = 8'h20;
  localparam logic [7:0] CMD_RDFL  = 8'h02;
  localparam logic [7:0] CMD_RDSIG = 8'h08;
  localparam logic [7:0] CMD_RDFUS = 8'h04;
`ifdef AVR_PP_RESP_EEPROM_EN
  localparam logic [7:0] CMD_EEWR  = 8'h11;
  localparam logic [7:0] CMD_EERD  = 8'h03;
  // Erase sweeps the larger of the two memories; the smaller one stops early.
  localparam int IW = (EE_AW > FLASH_AW) ? EE_AW : FLASH_AW;
`else
  localparam int IW = FLASH_AW;
  localparam int EE_AW_UNUSED = EE_AW;
`endif
  localparam int BCW = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES);

  // Synchronizer reset levels: {xtal, pagel, oe_n, wr_n, bs1, bs2, xa1, xa0}
  localparam logic [7:0] CTL_IDLE = 8'b0011_0000;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_PGWR, S_WAIT} state_t;

  state_t state, state_nx;

  logic [7:0]  ctl_s1, ctl_s2, data_s1, data_s2;
  logic        xtal_q, pagel_q, wr_n_q;
  logic        xtal_s, pagel_s, oe_n_s, wr_n_s, bs1_s, bs2_s, xa1_s, xa0_s;
  logic        xtal_rise, pagel_rise, wr_fall, wr_go, pagel_go;
  logic        go_erase, go_pgwr, go_fuse, go_lock, go_ee;
  logic [7:0]  cmd, fuse_lo, fuse_hi, lock, rd_byte;
  logic [15:0] addr, dat, rd_word;
  logic [IW-1:0]  idx;
  logic [BCW-1:0] busy_cnt;
  logic        addr_unused;

  logic [15:0] flash   [0:(2**FLASH_AW)-1];
  logic [15:0] pagebuf [0:(2**PAGE_AW)-1];
`ifdef AVR_PP_RESP_EEPROM_EN
  logic [7:0]  eeprom  [0:(2**EE_AW)-1];
`endif

  assign {xtal_s, pagel_s, oe_n_s, wr_n_s, bs1_s, bs2_s, xa1_s, xa0_s} = ctl_s2;
  assign xtal_rise   = xtal_s & ~xtal_q;
  assign pagel_rise  = pagel_s & ~pagel_q;
  assign wr_fall     = ~wr_n_s & wr_n_q;
  // A load strobe in the same cycle wins; the write strobe is dropped.
  assign wr_go       = (state == S_IDLE) && wr_fall && !xtal_rise;
  assign pagel_go    = (state == S_IDLE) && pagel_rise && !bs1_s && (cmd == CMD_PGWR);
  assign rdy_bsy     = (state == S_IDLE);
  assign addr_unused = &{1'b0, addr[15:FLASH_AW]};

  // Two-flop pin synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_s1  <= CTL_IDLE;
      ctl_s2  <= CTL_IDLE;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
      xtal_q  <= 1'b0;
      pagel_q <= 1'b0;
      wr_n_q  <= 1'b1;
    end else begin
      ctl_s1  <= {xtal, pagel, oe_n, wr_n, bs1, bs2, xa1, xa0};
      ctl_s2  <= ctl_s1;
      data_s1 <= data_in;
      data_s2 <= data_s1;
      xtal_q  <= xtal_s;
      pagel_q <= pagel_s;
      wr_n_q  <= wr_n_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and WR command dispatch
  always_comb begin
    state_nx = state;
    go_erase = 1'b0;
    go_pgwr  = 1'b0;
    go_fuse  = 1'b0;
    go_lock  = 1'b0;
    go_ee    = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_go) begin
          case (cmd)
            CMD_ERASE: begin go_erase = 1'b1; state_nx = S_ERASE; end
            CMD_PGWR:  begin go_pgwr  = 1'b1; state_nx = S_PGWR;  end
            CMD_FUSE:  begin go_fuse  = 1'b1; state_nx = S_WAIT;  end
            CMD_LOCK:  begin go_lock  = 1'b1; state_nx = S_WAIT;  end
`ifdef AVR_PP_RESP_EEPROM_EN
            CMD_EEWR:  begin go_ee    = 1'b1; state_nx = S_WAIT;  end
`endif
            default: ;
          endcase
        end
      end
      S_ERASE: if (idx == {IW{1'b1}}) state_nx = S_WAIT;
      S_PGWR:  if (idx[PAGE_AW-1:0] == {PAGE_AW{1'b1}}) state_nx = S_WAIT;
      S_WAIT:  if (busy_cnt == BCW'(BUSY_CYCLES - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Readback mux; everything reads as FFh while an operation is running
  always_comb begin
    rd_word = flash[addr[FLASH_AW-1:0]];
    rd_byte = 8'hFF;
    if (state == S_IDLE) begin
      case (cmd)
        CMD_RDFL:  rd_byte = bs1_s ? rd_word[15:8] : rd_word[7:0];
        CMD_RDSIG: begin
          case (addr[1:0])
            2'd0:    rd_byte = SIG0;
            2'd1:    rd_byte = SIG1;
            2'd2:    rd_byte = SIG2;
            default: rd_byte = 8'hFF;
          endcase
        end
        CMD_RDFUS: begin
          case ({bs2_s, bs1_s})
            2'b00:   rd_byte = fuse_lo;
            2'b11:   rd_byte = fuse_hi;
            2'b01:   rd_byte = lock;
            default: rd_byte = 8'hFF;
          endcase
        end
`ifdef AVR_PP_RESP_EEPROM_EN
        CMD_EERD:  rd_byte = eeprom[addr[EE_AW-1:0]];
`endif
        default:   rd_byte = 8'hFF;
      endcase
    end
  end

  // Control registers, operation counters and registered data pins
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= 8'h00;
      addr     <= 16'h0000;
      dat      <= 16'h0000;
      fuse_lo  <= FUSE_LO_RST;
      fuse_hi  <= FUSE_HI_RST;
      lock     <= 8'hFF;
      idx      <= '0;
      busy_cnt <= '0;
      data_out <= 8'hFF;
      data_oe  <= 1'b0;
    end else begin
      if (state == S_IDLE && xtal_rise) begin
        case ({xa1_s, xa0_s})
          2'b00: if (bs1_s) addr[15:8] <= data_s2; else addr[7:0] <= data_s2;
          2'b01: if (bs1_s) dat[15:8]  <= data_s2; else dat[7:0]  <= data_s2;
          2'b10: cmd <= data_s2;
          default: ;
        endcase
      end
      if (go_fuse) begin
        if (bs1_s) fuse_hi <= dat[7:0];
        else       fuse_lo <= dat[7:0];
      end
      if (go_lock)  lock <= lock & dat[7:0];
      if (go_erase) lock <= 8'hFF;
      if (state == S_ERASE || state == S_PGWR) idx <= idx + IW'(1);
      else                                     idx <= '0;
      if (state == S_WAIT) busy_cnt <= busy_cnt + BCW'(1);
      else                 busy_cnt <= '0;
      data_oe  <= ~oe_n_s;
      data_out <= oe_n_s ? 8'hFF : rd_byte;
    end
  end

  // Flash array: erase sweep and page commit
  always_ff @(posedge clk) begin
    if (!rst && state == S_ERASE && (idx >> FLASH_AW) == '0)
      flash[idx[FLASH_AW-1:0]] <= 16'hFFFF;
    if (!rst && state == S_PGWR)
      flash[{addr[FLASH_AW-1:PAGE_AW], idx[PAGE_AW-1:0]}] <= pagebuf[idx[PAGE_AW-1:0]];
  end

  // Page buffer: PAGEL loads, cleared word-by-word as the page is committed
  always_ff @(posedge clk) begin
    if (!rst && pagel_go)
      pagebuf[addr[PAGE_AW-1:0]] <= dat;
    if (!rst && state == S_PGWR)
      pagebuf[idx[PAGE_AW-1:0]] <= 16'hFFFF;
  end

`ifdef AVR_PP_RESP_EEPROM_EN
  // EEPROM: byte writes and erase sweep alongside flash
  always_ff @(posedge clk) begin
    if (!rst && state == S_ERASE && (idx >> EE_AW) == '0)
      eeprom[idx[EE_AW-1:0]] <= 8'hFF;
    if (!rst && go_ee)
      eeprom[addr[EE_AW-1:0]] <= dat[7:0];
  end
`endif

endmodule

// File: tb/tb_avr_pp_responder.sv
// tb/tb_avr_pp_responder.sv - scoreboard bench for avr_pp_responder
module tb_avr_pp_responder;
  localparam int NFLASH = 4096;
  localparam int NPAGE  = 32;
  localparam int BC     = 16;

  logic clk = 1'b0;
  logic rst, xtal, oe_n, wr_n, bs1, bs2, xa0, xa1, pagel;
  logic [7:0] data_in, data_out;
  logic data_oe, rdy_bsy;

  always #5 clk = ~clk;

  avr_pp_responder dut (
    .clk(clk), .rst(rst), .xtal(xtal), .oe_n(oe_n), .wr_n(wr_n),
    .bs1(bs1), .bs2(bs2), .xa0(xa0), .xa1(xa1), .pagel(pagel),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .rdy_bsy(rdy_bsy)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  string name_q[$];

  // Reference model of the emulated part
  logic [7:0]  m_cmd, m_fuse_lo, m_fuse_hi, m_lock;
  logic [15:0] m_addr, m_dat;
  logic [15:0] m_flash [int];
  logic [15:0] m_page [int];
  logic [7:0]  m_ee [int];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_cmd = 8'h00; m_addr = 16'h0; m_dat = 16'h0;
    m_fuse_lo = 8'hE1; m_fuse_hi = 8'hD9; m_lock = 8'hFF;
  endtask

  function automatic logic [7:0] model_read(input logic b1, input logic b2);
    logic [15:0] w;
    int a;
    case (m_cmd)
      8'h02: begin
        a = int'(m_addr) % NFLASH;
        w = m_flash.exists(a) ? m_flash[a] : 16'hxxxx;
        return b1 ? w[15:8] : w[7:0];
      end
      8'h08: begin
        case (int'(m_addr) % 4)
          0: return 8'h1E;
          1: return 8'h93;
          2: return 8'h07;
          default: return 8'hFF;
        endcase
      end
      8'h04: begin
        if (!b2 && !b1) return m_fuse_lo;
        if (b2 && b1) return m_fuse_hi;
        if (!b2 && b1) return m_lock;
        return 8'hFF;
      end
`ifdef AVR_PP_RESP_EEPROM_EN
      8'h03: return m_ee[int'(m_addr) % 512];
`endif
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xtal_load(input logic [1:0] xa, input logic b1, input logic [7:0] d);
    {xa1, xa0} = xa; bs1 = b1; data_in = d;
    tick(1); xtal = 1'b1; tick(4); xtal = 1'b0; tick(3);
    case (xa)
      2'b00: if (b1) m_addr[15:8] = d; else m_addr[7:0] = d;
      2'b01: if (b1) m_dat[15:8] = d; else m_dat[7:0] = d;
      2'b10: m_cmd = d;
      default: ;
    endcase
  endtask

  task automatic load_cmd(input logic [7:0] c);
    xtal_load(2'b10, 1'b0, c);
  endtask

  task automatic load_addr(input logic [15:0] a);
    xtal_load(2'b00, 1'b0, a[7:0]);
    xtal_load(2'b00, 1'b1, a[15:8]);
  endtask

  task automatic load_data(input logic [15:0] d);
    xtal_load(2'b01, 1'b0, d[7:0]);
    xtal_load(2'b01, 1'b1, d[15:8]);
  endtask

  task automatic pagel_pulse();
    bs1 = 1'b0; tick(1); pagel = 1'b1; tick(4); pagel = 1'b0; tick(3);
    if (m_cmd == 8'h10) m_page[int'(m_addr) % NPAGE] = m_dat;
  endtask

  // inject: 0 none, 1 XTAL address load while busy, 2 XTAL data load together with WR
  task automatic wr_op(input string nm, input logic b1, input int inject);
    int exp_busy, cnt, first, base;
    logic [7:0] d2;
    exp_busy = 0; cnt = 0; first = -1;
    bs1 = b1;
    d2 = 8'($urandom);
    if (inject == 2) begin {xa1, xa0} = 2'b01; data_in = d2; end
    tick(1);
    xtal = (inject == 2);
    wr_n = 1'b0;
    if (inject == 2) begin
      if (b1) m_dat[15:8] = d2; else m_dat[7:0] = d2;
    end else begin
      case (m_cmd)
        8'h80: begin
          exp_busy = NFLASH + BC;
          for (int i = 0; i < NFLASH; i++) m_flash[i] = 16'hFFFF;
          m_lock = 8'hFF;
`ifdef AVR_PP_RESP_EEPROM_EN
          for (int i = 0; i < 512; i++) m_ee[i] = 8'hFF;
`endif
        end
        8'h10: begin
          exp_busy = NPAGE + BC;
          base = ((int'(m_addr) % NFLASH) / NPAGE) * NPAGE;
          for (int i = 0; i < NPAGE; i++) begin
            if (m_page.exists(i)) m_flash[base + i] = m_page[i];
            else m_flash.delete(base + i);
            m_page[i] = 16'hFFFF;
          end
        end
        8'h40: begin
          exp_busy = BC;
          if (b1) m_fuse_hi = m_dat[7:0]; else m_fuse_lo = m_dat[7:0];
        end
        8'h20: begin exp_busy = BC; m_lock = m_lock & m_dat[7:0]; end
`ifdef AVR_PP_RESP_EEPROM_EN
        8'h11: begin exp_busy = BC; m_ee[int'(m_addr) % 512] = m_dat[7:0]; end
`endif
        default: exp_busy = 0;
      endcase
    end
    for (int k = 0; k < exp_busy + 30; k++) begin
      tick(1);
      if (k == 3) begin wr_n = 1'b1; xtal = 1'b0; end
      if (inject == 1 && k == 8) begin {xa1, xa0} = 2'b00; bs1 = 1'b0; data_in = 8'h5C; end
      if (inject == 1 && k == 9) xtal = 1'b1;
      if (inject == 1 && k == 13) xtal = 1'b0;
      if (!rdy_bsy) begin
        cnt++;
        if (first < 0) first = k;
      end else if (cnt > 0) break;
    end
    chk({nm, "_busy_len"}, cnt, exp_busy);
    if (exp_busy > 0) chk({nm, "_busy_start"}, first, 2);
    tick(3);
  endtask

  task automatic rd(input string nm, input logic b1, input logic b2);
    bs1 = b1; bs2 = b2; tick(1);
    exp_q.push_back(model_read(b1, b2));
    name_q.push_back(nm);
    oe_n = 1'b0;
    tick(2); chk({nm, "_oe_early"}, data_oe, 0);
    tick(1); chk({nm, "_oe_on"}, data_oe, 1);
    tick(2); oe_n = 1'b1;
    tick(3); chk({nm, "_oe_off"}, data_oe, 0);
    tick(1);
  endtask

  // Monitor: one scoreboard entry per data_oe assertion
  initial begin
    logic prev;
    string nm;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_oe && !prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_read: data_out %0h with nothing expected", data_out);
        end else begin
          nm = name_q.pop_front();
          chk(nm, data_out, exp_q.pop_front());
        end
      end
      prev = data_oe;
    end
  end

  initial begin
    #800000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] hi, r;
    int i;
    rst = 1'b1; xtal = 1'b0; oe_n = 1'b1; wr_n = 1'b1; bs1 = 1'b0; bs2 = 1'b0;
    xa0 = 1'b0; xa1 = 1'b0; pagel = 1'b0; data_in = 8'h00;
    model_reset();
    tick(3);
    chk("rst_rdy", rdy_bsy, 1);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 8'hFF);
    rst = 1'b0;
    tick(2);

    load_cmd(8'h08);
    for (int n = 0; n < 4; n++) begin
      load_addr(16'(n));
      rd("sig", 1'b0, 1'b0);
    end

    load_cmd(8'h10);
    for (int w = 0; w < NPAGE; w++) begin
      load_addr(16'h0100 + 16'(w));
      load_data(16'hA500 + 16'(w));
      pagel_pulse();
    end
    wr_op("page1", 1'b0, 0);
    load_cmd(8'h02);
    load_addr(16'h0105);
    rd("flash0105_lo", 1'b0, 1'b0);
    rd("flash0105_hi", 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      load_addr(16'h0100 + 16'($urandom_range(0, 31)));
      rd("page1_rand", 1'($urandom), 1'b0);
    end

    hi = 8'($urandom_range(2, 15));
    load_cmd(8'h10);
    for (int n = 0; n < 8; n++) begin
      load_addr({hi, 8'($urandom_range(0, 31))});
      load_data(16'($urandom));
      pagel_pulse();
    end
    wr_op("page2", 1'b0, 1);
    load_cmd(8'h02);
    rd("addr_kept_lo", 1'b0, 1'b0);
    rd("addr_kept_hi", 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      load_addr({hi, 8'($urandom_range(0, 31))});
      rd("page2_rand", 1'($urandom), 1'b0);
    end

    load_cmd(8'h40);
    load_data(16'h003F);
    wr_op("fuse_lo", 1'b0, 0);
    load_cmd(8'h04);
    rd("fuse_lo", 1'b0, 1'b0);
    rd("fuse_hi_rst", 1'b1, 1'b1);
    rd("fuse_10", 1'b0, 1'b1);
    load_cmd(8'h40);
    load_data(16'($urandom));
    wr_op("fuse_hi", 1'b1, 0);
    load_cmd(8'h04);
    rd("fuse_hi", 1'b1, 1'b1);

    load_cmd(8'h40);
    wr_op("xtal_wr_same", 1'b0, 2);
    load_cmd(8'h04);
    rd("fuse_lo_kept", 1'b0, 1'b0);
    load_cmd(8'h40);
    wr_op("fuse_lo2", 1'b0, 0);
    load_cmd(8'h04);
    rd("fuse_lo_injected", 1'b0, 1'b0);

    load_cmd(8'h20);
    load_data(16'h00FC);
    wr_op("lock1", 1'b0, 0);
    load_data(16'h00F3);
    wr_op("lock2", 1'b0, 0);
    load_cmd(8'h04);
    rd("lock_f0", 1'b1, 1'b0);
    load_cmd(8'h20);
    load_data(16'($urandom));
    wr_op("lock3", 1'b0, 0);
    load_cmd(8'h04);
    rd("lock_rand", 1'b1, 1'b0);

    load_cmd(8'h80);
    wr_op("erase", 1'b0, 0);
    load_cmd(8'h04);
    rd("lock_erased", 1'b1, 1'b0);
    load_cmd(8'h02);
    load_addr(16'h0105);
    rd("erased_lo", 1'b0, 1'b0);
    rd("erased_hi", 1'b1, 1'b0);

    load_cmd(8'h11);
    load_addr(16'h01F0);
    load_data(16'h005A);
    wr_op("ee_wr", 1'b0, 0);
    load_cmd(8'h03);
    rd("ee_rd", 1'b0, 1'b0);

    load_cmd(8'h80);
    bs1 = 1'b0;
    tick(1);
    wr_n = 1'b0;
    tick(60);
    chk("abort_busy", rdy_bsy, 0);
    rst = 1'b1; wr_n = 1'b1;
    tick(1);
    chk("abort_rdy", rdy_bsy, 1);
    rst = 1'b0;
    model_reset();
    m_flash.delete();
    tick(4);
    wr_op("post_rst_cmd00", 1'b0, 0);
    load_cmd(8'h04);
    rd("post_rst_fuse_lo", 1'b0, 1'b0);
    rd("post_rst_lock", 1'b1, 1'b0);

    tick(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    i = 0; r = 8'h00; hi = r; i = i;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
